camera_wr_synchro: RTL
======================

Name: camera_wr_synchro

Overview:
Write-side counterpart of the SDRAM frame-buffer path: takes camera pixel strobes (already in the `clk` domain) and produces the SDRAM write enable and write data. Writes begin only at a camera frame boundary (vsync rising edge), so each stored frame starts at buffer address 0. It aborts and re-aligns whenever the frame buffer is restarted (`sdram_rst_n` low on a game-state change). It also flags malformed frames and write overflow.

Parameters:
DW, 16, pixel / SDRAM write data width
H_PIX, 640, pixels per active line
V_LINES, 480, active lines per frame
CONTINUOUS, 1, 1 = re-arm for the next frame after completion; 0 = hold in DONE until restart
SKIP_FRAMES, 2, frames discarded after reset/restart (used only with CAM_WR_FRAME_SKIP_EN)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sdram_rst_n  in  1  active-low frame-buffer restart; low = abort and re-align
cam_vsync  in  1  camera vsync, high between frames; rising edge = new frame
cam_href  in  1  camera line valid
cam_pix_valid  in  1  one-cycle strobe per pixel, meaningful only while cam_href=1
cam_data  in  DW  pixel data, valid with cam_pix_valid
wr_full  in  1  SDRAM write FIFO full
sdram_wren  out  1  write enable, registered
sdram_wrdata  out  DW  write data, registered
frame_done  out  1  one-cycle pulse with the last pixel's write
frame_err  out  1  one-cycle pulse on a malformed frame
wr_overflow  out  1  sticky: a pixel was dropped because wr_full=1
frame_active  out  1  high while in ACTIVE

Behaviour:
- Reset (`rst`=1 at a clk edge): state=WAIT_VS; x_cnt=y_cnt=0; all outputs 0; vsync edge register cleared.
- vs_rise = cam_vsync & ~vs_d, where vs_d is cam_vsync registered. href_fall is detected the same way.
- Priority per cycle: rst > sdram_rst_n low > frame logic.
- sdram_rst_n low, in any state:
  - next state = WAIT_VS; counters cleared; wr_overflow cleared.
  - No write is issued that cycle or on any following cycle while it stays low.
  - A pending registered write still completes.
- States:
  - WAIT_VS: ignore pixels. On vs_rise go to ACTIVE with x=y=0.
  - ACTIVE: a pixel is accepted when cam_href & cam_pix_valid & ~wr_full.
    - On the cycle after an accepted pixel: sdram_wren=1 and sdram_wrdata=cam_data (latency 1). sdram_wren is 0 otherwise.
    - Each accepted pixel increments x_cnt.
    - If cam_pix_valid & cam_href & wr_full: the pixel is dropped, wr_overflow is set, and x_cnt still increments so geometry stays aligned.
    - On href_fall: if x_cnt==H_PIX, set x_cnt=0 and y_cnt+1. Otherwise pulse frame_err and go to WAIT_VS.
    - When the pixel that completes x=H_PIX-1 on line y=V_LINES-1 is counted: frame_done pulses in the same cycle as that pixel's sdram_wren. State goes to DONE (CONTINUOUS=0) or WAIT_VS (CONTINUOUS=1).
    - vs_rise in ACTIVE before completion: pulse frame_err, clear counters, stay ACTIVE (the new frame is captured).
    - cam_pix_valid while y_cnt==V_LINES: ignored.
  - DONE: no writes; leave only via sdram_rst_n low or rst.
- frame_active=1 exactly while state==ACTIVE, registered.
- Counter widths are $clog2(H_PIX+1) and $clog2(V_LINES+1). Counters never wrap: the frame-complete check precedes any increment.

Optional Feature:
CAM_WR_FRAME_SKIP_EN
- Defined: after rst or sdram_rst_n low, the first SKIP_FRAMES vs_rise events are counted but not captured. Capture begins on vs_rise number SKIP_FRAMES+1. While skipping, frame_active=0 and no frame_err is reported.
- Undefined: capture starts on the first vs_rise; SKIP_FRAMES is unused and the skip counter is not synthesized.

Test Plan:
- H_PIX=4, V_LINES=3, no full: vs_rise then 3 lines of 4 pixels 0x0001..0x000C -> 12 sdram_wren pulses with data 1..12, each 1 cycle after its strobe; frame_done coincides with data 0x000C; state returns to WAIT_VS.
- Pixels before the first vs_rise after rst -> no sdram_wren; capture starts at the pixel following vs_rise.
- wr_full=1 during pixel 6 of a 12-pixel frame -> 11 writes, data 6 missing, wr_overflow=1 until sdram_rst_n low, frame_done still pulses.
- Line 2 of only 3 pixels (href falls early) -> frame_err pulse at href_fall, no further writes until the next vs_rise.
- sdram_rst_n low mid-line 1 -> writes stop, wr_overflow clears; capture restarts cleanly at the next vs_rise with x=y=0.
- CAM_WR_FRAME_SKIP_EN, SKIP_FRAMES=2: three full frames after rst -> only the third is written (12 writes, one frame_done).

Source files
------------

// File: rtl/camera_wr_synchro.sv
// Camera-to-SDRAM write synchronizer: frame-aligned pixel capture with error/overflow flags.
// Optional CAM_WR_FRAME_SKIP_EN discards the first SKIP_FRAMES frames after (re)start.
module camera_wr_synchro #(
    parameter int DW          = 16,
    parameter int H_PIX       = 640,
    parameter int V_LINES     = 480,
    parameter int CONTINUOUS  = 1,
    parameter int SKIP_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sdram_rst_n,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic          cam_pix_valid,
    input  logic [DW-1:0] cam_data,
    input  logic          wr_full,
    output logic          sdram_wren,
    output logic [DW-1:0] sdram_wrdata,
    output logic          frame_done,
    output logic          frame_err,
    output logic          wr_overflow,
    output logic          frame_active
);

    localparam int XW = $clog2(H_PIX + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0] X_END  = XW'(H_PIX);
    localparam logic [XW-1:0] X_LAST = XW'(H_PIX - 1);
    localparam logic [YW-1:0] Y_END  = YW'(V_LINES);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

    typedef enum logic [1:0] {S_WAIT_VS, S_ACTIVE, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [XW-1:0]   r_x, w_x_nxt;
    logic [YW-1:0]   r_y, w_y_nxt;
    logic            r_vs_d, r_href_d;
    logic            w_vs_rise, w_href_fall, w_pix;
    logic            r_wren, w_wren_nxt;
    logic [DW-1:0]   r_wrdata;
    logic            r_done, w_done_nxt;
    logic            r_err, w_err_nxt;
    logic            r_ovf, w_ovf_nxt;
    logic            r_active;
    logic            w_skipping;

    assign w_vs_rise   = cam_vsync & ~r_vs_d;
    assign w_href_fall = ~cam_href & r_href_d;
    assign w_pix       = cam_href & cam_pix_valid;

`ifdef CAM_WR_FRAME_SKIP_EN
    localparam int SW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [SW-1:0] SKIP_N = SW'(SKIP_FRAMES);
    logic [SW-1:0] r_skip, w_skip_nxt;

    assign w_skipping = (r_skip != SKIP_N);

    always_comb begin
        w_skip_nxt = r_skip;
        if (!sdram_rst_n)
            w_skip_nxt = '0;
        else if (r_state == S_WAIT_VS && w_vs_rise && w_skipping)
            w_skip_nxt = r_skip + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_skip <= '0;
        else     r_skip <= w_skip_nxt;
    end
`else
    assign w_skipping = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_WAIT_VS;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_wren_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_ovf_nxt   = r_ovf;
        if (!sdram_rst_n) begin
            w_state_nxt = S_WAIT_VS;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_WAIT_VS: begin
                    if (w_vs_rise && !w_skipping) begin
                        w_state_nxt = S_ACTIVE;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                    end
                end
                S_ACTIVE: begin
                    if (w_vs_rise) begin
                        w_err_nxt = 1'b1;
                        w_x_nxt   = '0;
                        w_y_nxt   = '0;
                    end else if (w_href_fall) begin
                        if (r_x == X_END) begin
                            w_x_nxt = '0;
                            w_y_nxt = r_y + 1'b1;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_WAIT_VS;
                        end
                    end else if (w_pix && r_x != X_END && r_y != Y_END) begin
                        // Dropped pixels still advance x so line geometry stays aligned.
                        w_wren_nxt = ~wr_full;
                        if (wr_full) w_ovf_nxt = 1'b1;
                        if (r_x == X_LAST && r_y == Y_LAST) begin
                            w_done_nxt  = 1'b1;
                            w_x_nxt     = '0;
                            w_y_nxt     = '0;
                            w_state_nxt = (CONTINUOUS != 0) ? S_WAIT_VS : S_DONE;
                        end else begin
                            w_x_nxt = r_x + 1'b1;
                        end
                    end
                end
                S_DONE:  ;
                default: w_state_nxt = S_WAIT_VS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_vs_d   <= 1'b0;
            r_href_d <= 1'b0;
            r_wren   <= 1'b0;
            r_wrdata <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_vs_d   <= cam_vsync;
            r_href_d <= cam_href;
            r_wren   <= w_wren_nxt;
            if (w_wren_nxt) r_wrdata <= cam_data;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_ovf    <= w_ovf_nxt;
            r_active <= (w_state_nxt == S_ACTIVE);
        end
    end

    assign sdram_wren   = r_wren;
    assign sdram_wrdata = r_wrdata;
    assign frame_done   = r_done;
    assign frame_err    = r_err;
    assign wr_overflow  = r_ovf;
    assign frame_active = r_active;

endmodule
